// File: rtl/user_rom_arbiter.sv
// user_rom_arbiter: round-robin OBI arbiter sharing the single-port user-domain ROM
// between NumMgr managers. It forwards at most one request per cycle and steers each
// in-order response back through a small tracking FIFO of granted manager indices.
// Optional stall statistics counter: define USER_ROM_ARB_STATS_EN.

package user_rom_obi_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
    logic        a_optional;
  } obi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;
endpackage

module user_rom_arbiter #(
  parameter type         obi_req_t = user_rom_obi_pkg::obi_req_t,
  parameter type         obi_rsp_t = user_rom_obi_pkg::obi_rsp_t,
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned Depth     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    mgr_req_i [NumMgr],
  output obi_rsp_t    mgr_rsp_o [NumMgr],
  output obi_req_t    sbr_req_o,
  input  obi_rsp_t    sbr_rsp_i,
  output logic        orphan_o,
  output logic [15:0] stall_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumMgr);
  // A depth-1 FIFO still needs a 1-bit pointer; it simply always wraps to 0.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] win;
  logic [IdxW-1:0] head;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [IdxW-1:0] fifo_mem [Depth];
  logic            found;
  logic            arb_en;
  logic            pop;
  logic            push;
  logic            orphan_evt;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NumMgr - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign head       = fifo_mem[rd_ptr_q];
  // A response only pops when some grant is outstanding; otherwise it is an orphan.
  assign pop        = sbr_rsp_i.rvalid && (count_q != '0) && !rst_i;
  assign orphan_evt = sbr_rsp_i.rvalid && (count_q == '0) && !rst_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a grant.
  assign arb_en     = (count_q < CntW'(Depth)) || pop;
  assign push       = sbr_req_o.req && sbr_rsp_i.gnt;

  // Round-robin search starting at rr_q and wrapping modulo NumMgr.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < int'(NumMgr); k++) begin
      idx = (int'(rr_q) + k) % int'(NumMgr);
      if (!found && mgr_req_i[idx].req) begin
        found = 1'b1;
        win   = IdxW'(idx);
      end
    end
  end

  // Forward the winner's address channel unchanged to the ROM.
  always_comb begin
    sbr_req_o = '0;
    if (found && arb_en && !rst_i) begin
      sbr_req_o.req = 1'b1;
      sbr_req_o.a   = mgr_req_i[win].a;
    end
  end

  // Steer the grant to the winner and the response to the FIFO head.
  always_comb begin
    for (int i = 0; i < int'(NumMgr); i++) begin
      mgr_rsp_o[i] = '0;
    end
    if (sbr_req_o.req) begin
      mgr_rsp_o[win].gnt = sbr_rsp_i.gnt;
    end
    if (pop) begin
      mgr_rsp_o[head].rvalid = 1'b1;
      mgr_rsp_o[head].r      = sbr_rsp_i.r;
    end
  end

  // Control state: priority pointer, FIFO pointers/occupancy and sticky orphan flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_o <= 1'b0;
    end else begin
      if (push) begin
        rr_q     <= next_idx(win);
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      if (orphan_evt) begin
        orphan_o <= 1'b1;
      end
    end
  end

  // FIFO storage holds only manager indices; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= win;
    end
  end

`ifdef USER_ROM_ARB_STATS_EN
  logic [15:0] stall_q;
  logic        any_req;

  // Any manager asking this cycle.
  always_comb begin
    any_req = 1'b0;
    for (int i = 0; i < int'(NumMgr); i++) begin
      any_req = any_req | mgr_req_i[i].req;
    end
  end

  // Saturating count of cycles with pending requests but no handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (any_req && !push && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule
